// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS) requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is LS priority with an IF starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int TAIL = RD_LAT - 1;

    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;   // 1 = LS, 0 = IF
    logic              ls_win;

`ifdef MEM_ARB_RR_EN
    logic last_ls;

    // On conflict the requester that did not win last time goes first.
    always_comb ls_win = ls_req && (!if_req || !last_ls);

    always_ff @(posedge clk) begin
        if (!reset)
            last_ls <= 1'b0;
        else if (ls_gnt)
            last_ls <= 1'b1;
        else if (if_gnt)
            last_ls <= 1'b0;
    end
`else
    logic [2:0] stall_cnt;

    always_comb ls_win = ls_req && (!if_req || (stall_cnt != 3'(MAX_STALL)));

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= 3'd0;
        else if (if_req && !if_gnt)
            stall_cnt <= (stall_cnt == 3'd7) ? stall_cnt : stall_cnt + 3'd1;
        else
            stall_cnt <= 3'd0;
    end
`endif

    assign ls_gnt = reset && ls_win;
    assign if_gnt = reset && if_req && !ls_win;

    always_comb begin
        mem_addr  = ls_gnt ? ls_addr : if_addr;
        mem_wdata = ls_wdata;
        mem_we    = ls_gnt && ls_we;
    end

    // Writes enter as bubbles so returns stay aligned with grant order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
            pipe_valid[0] <= if_gnt || (ls_gnt && !ls_we);
            pipe_owner[0] <= ls_gnt;
        end
    end

    assign if_rvalid = reset && pipe_valid[TAIL] && !pipe_owner[TAIL];
    assign ls_rvalid = reset && pipe_valid[TAIL] && pipe_owner[TAIL];
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;
    assign busy      = reset && (|pipe_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a transaction-level model; MEM_ARB_RR_EN selects the arbitration model.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MAX_STALL = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;

    logic          if_gnt[2], if_rvalid[2], ls_gnt[2], ls_rvalid[2], mem_we[2], busy[2];
    logic [DW-1:0] if_rdata[2], ls_rdata[2], mem_wdata[2], mem_rdata[2];
    logic [AW-1:0] mem_addr[2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 16) ? 32'hD300_0000 : (32'hA000_0000 | DW'(a));
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem [64];
        logic [DW-1:0] dly [LAT];

        initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);

        always @(posedge clk) begin
            if (mem_we[g]) mem[mem_addr[g][5:0]] <= mem_wdata[g];
            dly[0] <= mem[mem_addr[g][5:0]];
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
        assign mem_rdata[g] = dly[LAT-1];

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_STALL(MAX_STALL)) dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
            .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    // Reference model: outstanding reads are a list of (instance, due cycle, owner, data).
    typedef struct {
        int            inst;
        int            due;
        logic          owner;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          pq[$];
    logic [DW-1:0] mmem[2][64];
    int            cyc = 0;
    int            denied = 0;
    logic          last_was_ls = 1'b0;
    logic          last_if_g = 1'b0;
    logic          last_ls_g = 1'b0;

    initial for (int g = 0; g < 2; g++) for (int i = 0; i < 64; i++) mmem[g][i] = init_word(i);

    always @(negedge clk) begin
        logic e_if, e_ls, e_busy, e_irv, e_lrv;
        logic [DW-1:0] e_data;
        int idx;
        if (reset) begin
            if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
                e_ls = !last_was_ls;
`else
                e_ls = (denied < MAX_STALL);
`endif
            end else begin
                e_ls = ls_req;
            end
            e_if = if_req && !e_ls;
        end else begin
            e_if = 1'b0;
            e_ls = 1'b0;
        end

        for (int g = 0; g < 2; g++) begin
            e_busy = 1'b0; e_irv = 1'b0; e_lrv = 1'b0; e_data = '0; idx = -1;
            for (int i = 0; i < pq.size(); i++)
                if (pq[i].inst == g) begin
                    e_busy = 1'b1;
                    if (idx < 0) idx = i;
                end
            if (idx >= 0 && pq[idx].due == cyc) begin
                e_irv  = !pq[idx].owner;
                e_lrv  = pq[idx].owner;
                e_data = pq[idx].data;
            end
            if (!reset) begin
                e_busy = 1'b0; e_irv = 1'b0; e_lrv = 1'b0;
            end
            chk($sformatf("i%0d_if_gnt", g), 64'(if_gnt[g]), 64'(e_if));
            chk($sformatf("i%0d_ls_gnt", g), 64'(ls_gnt[g]), 64'(e_ls));
            chk($sformatf("i%0d_mem_we", g), 64'(mem_we[g]), 64'(e_ls && ls_we));
            chk($sformatf("i%0d_mem_addr", g), 64'(mem_addr[g]), 64'(e_ls ? ls_addr : if_addr));
            if (!e_if) chk($sformatf("i%0d_mem_wdata", g), 64'(mem_wdata[g]), 64'(ls_wdata));
            chk($sformatf("i%0d_busy", g), 64'(busy[g]), 64'(e_busy));
            chk($sformatf("i%0d_if_rvalid", g), 64'(if_rvalid[g]), 64'(e_irv));
            chk($sformatf("i%0d_ls_rvalid", g), 64'(ls_rvalid[g]), 64'(e_lrv));
            if (e_irv) chk($sformatf("i%0d_if_rdata", g), 64'(if_rdata[g]), 64'(e_data));
            if (e_lrv) chk($sformatf("i%0d_ls_rdata", g), 64'(ls_rdata[g]), 64'(e_data));
            if (idx >= 0 && pq[idx].due == cyc) pq.delete(idx);
        end

        if (!reset) begin
            pq.delete();
            denied = 0;
            last_was_ls = 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (e_if)
                    pq.push_back('{g, cyc + lat_of(g), 1'b0, mmem[g][if_addr[5:0]]});
                if (e_ls && !ls_we)
                    pq.push_back('{g, cyc + lat_of(g), 1'b1, mmem[g][ls_addr[5:0]]});
                if (e_ls && ls_we)
                    mmem[g][ls_addr[5:0]] = ls_wdata;
            end
            denied = (if_req && !e_if) ? denied + 1 : 0;
            if (e_ls) last_was_ls = 1'b1;
            else if (e_if) last_was_ls = 1'b0;
        end
        last_if_g = e_if;
        last_ls_g = e_ls;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_if;
        #6;
        chk("lit_rst_busy", 64'(busy[0]), 64'd0);
        chk("lit_rst_mem_we", 64'(mem_we[0]), 64'd0);
        step(); step();
        reset = 1'b1;

        // IF-only read of 0x0010
        step();
        if_req = 1'b1; if_addr = 16'h0010;
        #5 chk("lit_if_gnt", 64'(if_gnt[0]), 64'd1);
        step();
        if_req = 1'b0;
        #5;
        chk("lit_if_rvalid", 64'(if_rvalid[0]), 64'd1);
        chk("lit_if_rdata", 64'(if_rdata[0]), 64'hD300_0000);
        chk("lit_if_ls_rvalid", 64'(ls_rvalid[0]), 64'd0);

        // LS write then read-back of 0x0020
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 32'h0000_0055;
        #5 chk("lit_wr_mem_we", 64'(mem_we[0]), 64'd1);
        step();
        ls_we = 1'b0;
        #5;
        chk("lit_rd_mem_we", 64'(mem_we[0]), 64'd0);
        chk("lit_rd_ls_gnt", 64'(ls_gnt[0]), 64'd1);
        step();
        ls_req = 1'b0;
        #5;
        chk("lit_rd_ls_rvalid", 64'(ls_rvalid[0]), 64'd1);
        chk("lit_rd_ls_rdata", 64'(ls_rdata[0]), 64'h0000_0055);

        // Both requesting continuously from a fresh reset
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        if_req = 1'b1; if_addr = 16'h0005;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0006;
        for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_if = (k % 2) == 1;
`else
            exp_if = (k % 5) == 4;
`endif
            #5 chk($sformatf("lit_arb_k%0d", k), 64'(if_gnt[0]), 64'(exp_if));
            step();
        end
        if_req = 1'b0; ls_req = 1'b0;

        // Three back-to-back IF reads on the latency-3 instance
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        if_req = 1'b1; if_addr = 16'h0001;
        #5 chk("lit_l3_gnt", 64'(if_gnt[1]), 64'd1);
        step(); if_addr = 16'h0002;
        #5 chk("lit_l3_busy1", 64'(busy[1]), 64'd1);
        chk("lit_l3_rv1", 64'(if_rvalid[1]), 64'd0);
        step(); if_addr = 16'h0003;
        #5 chk("lit_l3_busy2", 64'(busy[1]), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            step(); if_req = 1'b0;
            #5;
            chk($sformatf("lit_l3_rv_a%0d", k), 64'(if_rvalid[1]), 64'd1);
            chk($sformatf("lit_l3_data_a%0d", k), 64'(if_rdata[1]), 64'(32'hA000_0000 | 32'(k)));
            chk($sformatf("lit_l3_busy_a%0d", k), 64'(busy[1]), 64'd1);
        end
        step();
        #5 chk("lit_l3_idle", 64'(busy[1]), 64'd0);

        // LS read discarded by a reset pulse before its return
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0007;
        #5 chk("lit_rst_ls_gnt_pre", 64'(ls_gnt[1]), 64'd1);
        step();
        reset = 1'b0; if_req = 1'b1;
        #5;
        chk("lit_rst_busy1", 64'(busy[1]), 64'd0);
        chk("lit_rst_if_gnt", 64'(if_gnt[1]), 64'd0);
        chk("lit_rst_ls_gnt", 64'(ls_gnt[1]), 64'd0);
        chk("lit_rst_ls_rv0", 64'(ls_rvalid[0]), 64'd0);
        step();
        reset = 1'b1; if_req = 1'b0; ls_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #5 chk($sformatf("lit_rst_no_rv%0d", k), 64'(ls_rvalid[1]), 64'd0);
            step();
        end

        // Randomized traffic with occasional reset pulses
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 149) != 0);
            if (!if_req || last_if_g) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom_range(0, 63));
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!ls_req || last_ls_g) begin
                ls_req   = ($urandom_range(0, 2) != 0);
                ls_we    = 1'($urandom_range(0, 1));
                ls_addr  = AW'($urandom_range(0, 63));
                ls_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                ls_req = 1'b0;
            end
            step();
        end
        if_req = 1'b0; ls_req = 1'b0; reset = 1'b1;
        for (int k = 0; k < 6; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
